// File: rtl/common.sv
// Shared core package: opcode constants, ALU/MUL op encodings and the decoded bundle.
// decode_queue and rv64_decode_comb import it.
package common;

   localparam logic [6:0] LOAD      = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] AUIPC     = 7'b0010111;
   localparam logic [6:0] OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] STORE     = 7'b0100011;
   localparam logic [6:0] OP        = 7'b0110011;
   localparam logic [6:0] LUI       = 7'b0110111;
   localparam logic [6:0] OP_32     = 7'b0111011;
   localparam logic [6:0] BRANCH    = 7'b1100011;
   localparam logic [6:0] JALR      = 7'b1100111;
   localparam logic [6:0] JAL       = 7'b1101111;

   localparam logic [1:0] SRC_A_ZERO = 2'b00;
   localparam logic [1:0] SRC_A_RS1  = 2'b01;
   localparam logic [1:0] SRC_A_PC   = 2'b10;
   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_IMM  = 2'b01;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_XOR  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_AND  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_t;

   // Mirrors funct3 of the M extension so execute can reuse the field directly.
   typedef enum logic [3:0] {
      MUL_MUL    = 4'd0,
      MUL_MULH   = 4'd1,
      MUL_MULHSU = 4'd2,
      MUL_MULHU  = 4'd3,
      MUL_DIV    = 4'd4,
      MUL_DIVU   = 4'd5,
      MUL_REM    = 4'd6,
      MUL_REMU   = 4'd7
   } mul_op_t;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
      logic [63:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      alu_op_t     aluOp;
      mul_op_t     mulOp;
      logic        rv64;
      logic        rvm;
      logic [1:0]  srcA;
      logic [1:0]  srcB;
      logic        isBranch;
      logic [2:0]  brCond;
      logic        isJal;
      logic        isJalr;
      logic        isWriteBack;
      logic        isMemRead;
      logic        isMemWrite;
      logic [3:0]  memMode;
      logic        illegal;
   } decoded_t;

   function automatic alu_op_t alu_from_f3(input logic [2:0] f3);
      case (f3)
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         3'b111:  return ALU_AND;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and execute-side handshakes of the decode queue.
// slave is the queue, master is the fetch/execute pair driving it.
interface decode_queue_if
   import common::*;
#(
   parameter int CNT_W = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [63:0]      in_pc;
   logic             out_valid;
   logic             out_ready;
   decoded_t         out_dec;
   logic [CNT_W-1:0] count;

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_dec, count
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_dec, count
   );
endinterface

// File: rtl/decode_queue_decode.sv
// rv64_decode_comb: purely combinational RV64IM decode of one instruction into decoded_t.
// DECODE_ILLEGAL_TRAP_EN reports undecodable instructions via the illegal flag; otherwise they become NOPs.
module rv64_decode_comb
   import common::*;
(
   input  logic [31:0] instr,
   input  logic [63:0] pc,
   output decoded_t    dec
);
   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [5:0]  f6;
   logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        ill;
   decoded_t    d;

   assign opc = instr[6:0];
   assign f3  = instr[14:12];
   assign f7  = instr[31:25];
   assign f6  = instr[31:26];

   assign imm_i = {{52{instr[31]}}, instr[31:20]};
   assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
   assign imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   always_comb begin
      d        = '0;
      ill      = 1'b0;
      d.pc     = pc;
      d.instr  = instr;
      d.rs1    = instr[19:15];
      d.rs2    = instr[24:20];
      d.rd     = instr[11:7];
      d.aluOp  = ALU_ADD;
      d.mulOp  = MUL_MUL;
      d.srcA   = SRC_A_RS1;
      d.srcB   = SRC_B_RS2;
      d.brCond = f3;

      case (opc)
         LOAD: begin
            d.imm         = imm_i;
            d.srcB        = SRC_B_IMM;
            d.isMemRead   = 1'b1;
            d.isWriteBack = 1'b1;
            d.memMode     = {1'b0, f3};
            ill           = (f3 == 3'b111);
         end
         STORE: begin
            d.imm        = imm_s;
            d.srcB       = SRC_B_IMM;
            d.isMemWrite = 1'b1;
            d.memMode    = {1'b1, f3};
            ill          = f3[2];
         end
         OP_IMM: begin
            d.imm         = imm_i;
            d.srcB        = SRC_B_IMM;
            d.isWriteBack = 1'b1;
            d.aluOp       = alu_from_f3(f3);
            // 64-bit shamt uses instr[25], so only funct6 qualifies the shift.
            if (f3 == 3'b001)
               ill = (f6 != 6'b000000);
            else if (f3 == 3'b101) begin
               if (f6 == 6'b010000)
                  d.aluOp = ALU_SRA;
               else
                  ill = (f6 != 6'b000000);
            end
         end
         OP_IMM_32: begin
            d.imm         = imm_i;
            d.srcB        = SRC_B_IMM;
            d.isWriteBack = 1'b1;
            d.rv64        = 1'b1;
            case (f3)
               3'b000: d.aluOp = ALU_ADD;
               3'b001: begin
                  d.aluOp = ALU_SLL;
                  ill     = (f7 != 7'b0000000);
               end
               3'b101: begin
                  if (f7 == 7'b0100000)
                     d.aluOp = ALU_SRA;
                  else begin
                     d.aluOp = ALU_SRL;
                     ill     = (f7 != 7'b0000000);
                  end
               end
               default: ill = 1'b1;
            endcase
         end
         OP: begin
            d.isWriteBack = 1'b1;
            if (f7 == 7'b0000001) begin
               d.rvm   = 1'b1;
               d.mulOp = mul_op_t'({1'b0, f3});
            end else if (f7 == 7'b0000000)
               d.aluOp = alu_from_f3(f3);
            else if (f7 == 7'b0100000) begin
               if (f3 == 3'b000)
                  d.aluOp = ALU_SUB;
               else if (f3 == 3'b101)
                  d.aluOp = ALU_SRA;
               else
                  ill = 1'b1;
            end else
               ill = 1'b1;
         end
         OP_32: begin
            d.isWriteBack = 1'b1;
            d.rv64        = 1'b1;
            if (f7 == 7'b0000001) begin
               d.rvm   = 1'b1;
               d.mulOp = mul_op_t'({1'b0, f3});
               ill     = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b011);
            end else if (f7 == 7'b0000000) begin
               d.aluOp = alu_from_f3(f3);
               ill     = !((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b101));
            end else if (f7 == 7'b0100000) begin
               d.aluOp = (f3 == 3'b101) ? ALU_SRA : ALU_SUB;
               ill     = !((f3 == 3'b000) || (f3 == 3'b101));
            end else
               ill = 1'b1;
         end
         LUI: begin
            d.imm         = imm_u;
            d.srcA        = SRC_A_ZERO;
            d.srcB        = SRC_B_IMM;
            d.isWriteBack = 1'b1;
         end
         AUIPC: begin
            d.imm         = imm_u;
            d.srcA        = SRC_A_PC;
            d.srcB        = SRC_B_IMM;
            d.isWriteBack = 1'b1;
         end
         JAL: begin
            d.imm         = imm_j;
            d.srcA        = SRC_A_PC;
            d.srcB        = SRC_B_IMM;
            d.isJal       = 1'b1;
            d.isWriteBack = 1'b1;
         end
         JALR: begin
            d.imm         = imm_i;
            d.srcB        = SRC_B_IMM;
            d.isJalr      = 1'b1;
            d.isWriteBack = 1'b1;
            ill           = (f3 != 3'b000);
         end
         BRANCH: begin
            d.imm      = imm_b;
            d.aluOp    = ALU_SUB;
            d.isBranch = 1'b1;
            ill        = (f3 == 3'b010) || (f3 == 3'b011);
         end
         default: ill = 1'b1;
      endcase

      if (d.rd == 5'd0)
         d.isWriteBack = 1'b0;

      // Undecodable entries never cause side effects, whether or not they trap.
      if (ill) begin
         d.aluOp       = ALU_ADD;
         d.rvm         = 1'b0;
         d.isWriteBack = 1'b0;
         d.isMemRead   = 1'b0;
         d.isMemWrite  = 1'b0;
         d.isBranch    = 1'b0;
         d.isJal       = 1'b0;
         d.isJalr      = 1'b0;
      end

`ifdef DECODE_ILLEGAL_TRAP_EN
      d.illegal = ill;
`else
      d.illegal = 1'b0;
`endif
   end

   assign dec = d;
endmodule

// File: rtl/decode_queue.sv
// Decode stage FIFO: decode on entry, DEPTH-entry queue to execute; 1-cycle min latency, no bypass.
// in_ready = not full (independent of out_ready); flush drops everything incl. the same-cycle push.
module decode_queue
   import common::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
)(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          flush,
   decode_queue_if.slave q
);
   localparam int AW = $clog2(DEPTH);

   decoded_t         mem [DEPTH];
   decoded_t         dec_in;
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic [CNT_W-1:0] cnt;
   logic             full, empty, push, pop;

   rv64_decode_comb u_dec (
      .instr (q.in_instr),
      .pc    (q.in_pc),
      .dec   (dec_in)
   );

   assign full  = (cnt == CNT_W'(DEPTH));
   assign empty = (cnt == '0);
   assign push  = q.in_valid && !full && !flush;
   assign pop   = q.out_ready && !empty && !flush;

   assign q.in_ready  = !full;
   assign q.out_valid = !empty;
   assign q.out_dec   = empty ? '0 : mem[rd_ptr];
   assign q.count     = cnt;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= dec_in;
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end
endmodule
